ex_operand_stage: RTL
=====================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: FWD_EN, 1, 1 enables operand forwarding; 0 disables forwarding and always uses the captured register data.
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  decode presents an instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN each  decoded PC, register-file operands and immediate.
REQ-008 in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  register indices.
REQ-009 in_alu_sel  in  4  ALU operation code from the shared package.
REQ-010 in_a_sel  in  2  operand-A source: 0 = rs1, 1 = pc, 2 = zero, 3 = zero.
REQ-011 in_b_sel  in  1  operand-B source: 0 = rs2, 1 = imm.
REQ-012 flush  in  1  kill the held instruction.
REQ-013 fwd_mem_valid, fwd_wb_valid  in  1 each  forwarding source is writing a register.
REQ-014 fwd_mem_rd, fwd_wb_rd  in  5 each  forwarding destination index.
REQ-015 fwd_mem_data, fwd_wb_data  in  XLEN each  forwarding value.
REQ-016 out_valid  out  1  a, b, alu_sel and out_rd_addr are valid.
REQ-017 out_ready  in  1  the downstream ALU/EX stage consumes this cycle.
REQ-018 a, b  out  XLEN each  ALU operands.
REQ-019 alu_sel  out  4  ALU operation code.
REQ-020 out_rd_addr  out  5  destination register passed to the next stage.

Function
REQ-021 The stage SHALL hold a single entry, with in_ready = !out_valid || out_ready (combinational).
REQ-022 On in_valid && in_ready && !flush, the stage SHALL capture all in_* fields at the edge and assert out_valid the next cycle (1-cycle latency).
REQ-023 When out_valid && out_ready with no new capture, out_valid SHALL deassert at the next edge.
REQ-024 When out_valid && !out_ready, all outputs SHALL stay stable apart from the forwarding refresh in REQ-027.
REQ-025 flush SHALL clear out_valid at the next edge and SHALL win over a simultaneous capture; captured data may be left unchanged.
REQ-026 Each held rs operand SHALL use forwarded data when the held address is nonzero and a forwarding source is valid with a matching rd: MEM has priority over WB, then the captured data is used.
REQ-027 While holding, any forwarding hit SHALL be written back into the held operand register at the edge, so the value survives once the source retires.
REQ-028 At the capture edge, forwarding SHALL also be applied to the incoming rs data, so an instruction entering behind a producer sees the producer's value.
REQ-029 Index x0 SHALL never be forwarded; a and b SHALL read the captured value (0 from the register file).
REQ-030 a SHALL be muxed from the forwarded rs1, the held pc or zero per the held a_sel; b SHALL be the forwarded rs2 or the held imm per b_sel.
REQ-031 The forwarding mux and the operand mux SHALL be combinational from held state and the fwd_* inputs; there is no extra latency.

Reset
REQ-032 When reset is low, out_valid SHALL be 0, all held data 0, alu_sel the package ALU_ADD code, and out_rd_addr 0, asynchronously.
REQ-033 Reset asserted mid-hold SHALL discard the entry; in_ready SHALL be 1 during reset and in the first cycle after release.
REQ-034 Reset deassertion SHALL take effect at the next clk edge.

Structure
REQ-035 The ALU_* codes and the operand-A/B source encodings SHALL live in the shared types package; no local literals are permitted.
REQ-036 A sub-module fwd_mux (address, captured data, both forwarding ports -> selected data) SHALL be instantiated once per rs operand.

Verification
REQ-037 Capture test: hold out_ready=1; send rs1_data=5, rs2_data=7, a_sel=0, b_sel=0, alu_sel=ADD -> next cycle out_valid=1, a=5, b=7.
REQ-038 Backpressure test: hold out_ready=0 for 3 cycles -> in_ready=0 and a, b stable; one cycle after out_ready=1 -> out_valid=0.
REQ-039 Forwarding priority test: held rs1_addr=3; MEM rd=3 with data 0xAA and WB rd=3 with data 0xBB -> a=0xAA; with only WB valid -> a=0xBB.
REQ-040 Refresh test: stalled with MEM rd=4 = 0x11 for one cycle, then the source drops -> a remains 0x11.
REQ-041 x0 test: rs1_addr=0 with MEM rd=0 and data 0xFF -> a=0.
REQ-042 Flush and reset test: flush and in_valid together -> out_valid=0 the next cycle; reset low mid-hold -> out_valid=0 immediately and alu_sel=ALU_ADD.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the EX operand stage: ALU operation codes, operand
// source encodings and register-index constants.
package ex_operand_stage_pkg;

  localparam int ALU_SEL_W  = 4;
  localparam int REG_ADDR_W = 5;

  // ALU operation codes carried through the stage untouched.
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Operand-A source select. Both upper encodings give zero.
  localparam logic [1:0] A_SEL_RS1      = 2'd0;
  localparam logic [1:0] A_SEL_PC       = 2'd1;
  localparam logic [1:0] A_SEL_ZERO     = 2'd2;
  localparam logic [1:0] A_SEL_ZERO_ALT = 2'd3;

  // Operand-B source select.
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  // Hard-wired zero register; never a forwarding target.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding selector: picks the MEM result, then the WB result,
// then the captured register-file value for one source register.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       cap_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       data
);

  logic mem_hit;
  logic wb_hit;

  // x0 is excluded so a stray write to r0 downstream can never leak in.
  assign mem_hit = (FWD_EN != 0) && (addr != REG_X0) && mem_valid && (mem_rd == addr);
  assign wb_hit  = (FWD_EN != 0) && (addr != REG_X0) && wb_valid  && (wb_rd  == addr);

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    data = cap_data;
    if (mem_hit) begin
      data = mem_data;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Single-entry operand stage between decode and the ALU. Holds one
// instruction, forwards in-flight results into its source operands and
// presents the selected ALU operands with a valid/ready handshake.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [ALU_SEL_W-1:0]  in_alu_sel,
  input  logic [1:0]            in_a_sel,
  input  logic                  in_b_sel,
  input  logic                  flush,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       a,
  output logic [XLEN-1:0]       b,
  output logic [ALU_SEL_W-1:0]  alu_sel,
  output logic [REG_ADDR_W-1:0] out_rd_addr
);

  logic                  valid_reg;
  logic                  valid_next;
  logic                  capture;
  logic [XLEN-1:0]       pc_reg;
  logic [XLEN-1:0]       imm_reg;
  logic [1:0]            a_sel_reg;
  logic                  b_sel_reg;
  logic [ALU_SEL_W-1:0]  alu_sel_reg;
  logic [REG_ADDR_W-1:0] rd_reg;

  // Index 0 is rs1, index 1 is rs2.
  logic [XLEN-1:0]       rs_data_reg [2];
  logic [REG_ADDR_W-1:0] rs_addr_reg [2];
  logic [XLEN-1:0]       rs_fwd      [2];
  logic [XLEN-1:0]       rs_in_fwd   [2];
  logic [XLEN-1:0]       in_rs_data  [2];
  logic [REG_ADDR_W-1:0] in_rs_addr  [2];

  assign in_rs_data[0] = in_rs1_data;
  assign in_rs_data[1] = in_rs2_data;
  assign in_rs_addr[0] = in_rs1_addr;
  assign in_rs_addr[1] = in_rs2_addr;

  assign in_ready = !valid_reg || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Occupancy: flush beats a capture, a capture refills, a consume empties.
  always_comb begin
    valid_next = valid_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (capture) begin
      valid_next = 1'b1;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Non-operand fields only change on a capture; a flush leaves them as is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= '0;
      imm_reg     <= '0;
      a_sel_reg   <= A_SEL_RS1;
      b_sel_reg   <= B_SEL_RS2;
      alu_sel_reg <= ALU_ADD;
      rd_reg      <= REG_X0;
    end else if (capture) begin
      pc_reg      <= in_pc;
      imm_reg     <= in_imm;
      a_sel_reg   <= in_a_sel;
      b_sel_reg   <= in_b_sel;
      alu_sel_reg <= in_alu_sel;
      rd_reg      <= in_rd_addr;
    end
  end

  // Per source operand: one selector looks at the held entry (drives the
  // outputs and the refresh), the other at the incoming instruction so a
  // producer retiring on the capture edge is not missed.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
      fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_held (
        .addr      (rs_addr_reg[gi]),
        .cap_data  (rs_data_reg[gi]),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .data      (rs_fwd[gi])
      );

      fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_in (
        .addr      (in_rs_addr[gi]),
        .cap_data  (in_rs_data[gi]),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .data      (rs_in_fwd[gi])
      );

      // Load the forwarded incoming value on capture; while holding, write
      // back any forwarding hit so it outlives the producer.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rs_data_reg[gi] <= '0;
          rs_addr_reg[gi] <= REG_X0;
        end else if (capture) begin
          rs_data_reg[gi] <= rs_in_fwd[gi];
          rs_addr_reg[gi] <= in_rs_addr[gi];
        end else if (valid_reg) begin
          rs_data_reg[gi] <= rs_fwd[gi];
        end
      end
    end
  endgenerate

  // Operand selection from the held entry and the live forwarding inputs.
  always_comb begin
    a = '0;
    case (a_sel_reg)
      A_SEL_RS1:      a = rs_fwd[0];
      A_SEL_PC:       a = pc_reg;
      A_SEL_ZERO:     a = '0;
      A_SEL_ZERO_ALT: a = '0;
      default:        a = '0;
    endcase
    b = (b_sel_reg == B_SEL_IMM) ? imm_reg : rs_fwd[1];
  end

  assign out_valid   = valid_reg;
  assign alu_sel     = alu_sel_reg;
  assign out_rd_addr = rd_reg;

endmodule
